fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register.
- Owns the program counter and issues word requests to instruction memory over a req/ready handshake.
- Holds one fetched instruction in an output slot until the IF/ID register accepts it; the slot is consumed on any edge where stall=0.
- Applies branch/jump redirects from downstream, which flush the slot and restart fetch at the target.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hazard-unit stall; IF/ID enable is ~stall, so slot is consumed on edges where stall=0.
- redirect  input  1  branch/jump taken; flush and refetch.
- redirect_pc  input  32  redirect target; bits [1:0] forced to 0.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch address (= pc).
- imem_ready  input  1  memory accepts request and returns data in the same cycle.
- imem_rdata  input  32  instruction word, valid when imem_req && imem_ready.
- if_valid  output  1  slot holds a real instruction; 0 means bubble.
- if_instr  output  32  instruction to IF/ID (0x0000_0000 = NOP when invalid).
- if_pc_plus4  output  32  fetch PC + PC_STEP, to IF/ID.

Behaviour:
- Reset (async, immediate while rst=1):
  - pc=RESET_PC, state=BOOT.
  - if_valid=0, if_instr=0, if_pc_plus4=0, imem_req=0.
- States:
  - BOOT: imem_req=0; moves to RUN on the first edge after rst deasserts.
  - RUN: normal operation.
- Request gating: in RUN, imem_req = !redirect && (!if_valid || !stall). The request is issued when the slot is empty or is being consumed this edge. imem_addr=pc in all states.
- Accept: an edge with imem_req && imem_ready does:
  - slot <= {1, imem_rdata, pc+PC_STEP};
  - pc <= pc+PC_STEP.
  - Sustains one instruction per cycle with zero bubbles while ready=1 and stall=0.
- Slot consumed with no accept (stall=0, no fill): if_valid<=0, if_instr<=0. if_pc_plus4 holds its value.
- Stall with full slot: slot and pc hold; imem_req=0.
- Stall with empty slot: a fetch proceeds and fills the slot, then holds.
- Memory not ready: the request stays asserted with an unchanged address. The slot drains normally if stall=0.
- Redirect (highest priority, overrides stall and any same-cycle imem_ready):
  - pc <= {redirect_pc[31:2],2'b00};
  - if_valid<=0, if_instr<=0;
  - returned data is discarded; imem_req=0 that cycle.
  - Fetch resumes at the target the next cycle.
  - Instruction memory tolerates request withdrawal without ready.
- Redirect during BOOT: pc is loaded with the target, state moves to RUN.
- PC arithmetic is 32-bit modulo: 0xFFFF_FFFC+4 = 0x0000_0000, no flag.
- Reset mid-operation clears everything asynchronously. The first request goes out at RESET_PC two edges after deassert (BOOT, then RUN).
- Latency: instruction at address A appears on if_* one edge after its accept. Redirect-to-valid is 2 edges with a ready memory.

Test Plan:
- Reset, then release with RESET_PC=0 and imem_ready=1, memory returning addr+0x100:
  - if_* stay 0 during rst;
  - BOOT cycle has req=0;
  - then if_instr=0x100,0x104,0x108 with if_pc_plus4=4,8,12 on consecutive edges, if_valid=1.
- stall=1 for 3 cycles with the slot holding 0x108:
  - imem_req=0, pc=12, if_* unchanged;
  - on stall release, 0x10C follows on the next edge with no gap or duplicate.
- imem_ready=0 for 2 cycles with stall=0:
  - imem_addr held;
  - if_valid drops to 0 after one edge (bubble) and returns on ready.
- redirect=1 with redirect_pc=0x0000_0403 and imem_ready=1 in the same cycle:
  - returned data discarded, if_valid=0, pc=0x400;
  - next fetch addr=0x400, valid 2 edges later.
- redirect and stall both high with a full slot: slot flushed (if_valid=0), pc=target.
- pc=0xFFFF_FFFC fetch: if_pc_plus4=0x0000_0000 and the next imem_addr=0.
- Assert rst mid-stream with if_valid=1: outputs clear immediately, without waiting for clk.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory handshake, IF/ID slot outputs and downstream control.
// The fetch stage is the master; the memory/pipeline side is the slave.
interface fetch_stage_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc_plus4;

    modport master (
        input  stall, redirect, redirect_pc, imem_ready, imem_rdata,
        output imem_req, imem_addr, if_valid, if_instr, if_pc_plus4
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_ready, imem_rdata,
        input  imem_req, imem_addr, if_valid, if_instr, if_pc_plus4
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready handshake and
// holds one instruction in a slot feeding the IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    typedef enum logic {BOOT, RUN} state_t;

    state_t      state;
    logic [31:0] pc;
    logic        vld_p1;
    logic [31:0] instr_p1;
    logic [31:0] pcPlus4_p1;
    logic        fetchReq;
    logic        accept;
    logic [31:0] pcNext;

    function automatic logic [31:0] alignWord(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    function automatic logic [31:0] stepPc(input logic [31:0] addr);
        return addr + PC_STEP;
    endfunction

    // Fetch only when the slot is empty or drains this edge; a redirect withdraws the request.
    assign fetchReq = (state == RUN) && !bus.redirect && (!vld_p1 || !bus.stall);
    assign accept   = fetchReq && bus.imem_ready;
    assign pcNext   = stepPc(pc);

    // ---- stage p0 -> p1: PC update and slot fill ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            vld_p1     <= 1'b0;
            instr_p1   <= 32'h0;
            pcPlus4_p1 <= 32'h0;
        end else if (bus.redirect) begin
            state    <= RUN;
            pc       <= alignWord(bus.redirect_pc);
            vld_p1   <= 1'b0;
            instr_p1 <= 32'h0;
        end else if (state == BOOT) begin
            state <= RUN;
        end else if (accept) begin
            pc         <= pcNext;
            vld_p1     <= 1'b1;
            instr_p1   <= bus.imem_rdata;
            pcPlus4_p1 <= pcNext;
        end else if (!bus.stall) begin
            // Slot consumed by IF/ID with nothing to refill it: leave a NOP bubble.
            vld_p1   <= 1'b0;
            instr_p1 <= 32'h0;
        end
    end

    assign bus.imem_req    = fetchReq;
    assign bus.imem_addr   = pc;
    assign bus.if_valid    = vld_p1;
    assign bus.if_instr    = instr_p1;
    assign bus.if_pc_plus4 = pcPlus4_p1;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory returns addr+0x100 for every fetch.
module tb_fetch_stage;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    fetch_stage_if bus();

    fetch_stage #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.imem_rdata = bus.imem_addr + 32'h100;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.imem_ready = 1'b1;
        tick();
        tick();
        total++;
        if ({bus.if_valid, bus.if_instr, bus.if_pc_plus4, bus.imem_req} !== 66'h0) begin
            bad++;
            $display("FAIL reset_outputs got v=%b i=%h p=%h req=%b want all zero",
                     bus.if_valid, bus.if_instr, bus.if_pc_plus4, bus.imem_req);
        end
        rst = 1'b0;
        #1;
        total++;
        if (bus.imem_req !== 1'b0) begin
            bad++;
            $display("FAIL boot_req got %b want 0", bus.imem_req);
        end
        tick();
        total++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
            bad++;
            $display("FAIL run_first_req got req=%b addr=%h want 1/00000000", bus.imem_req, bus.imem_addr);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (bus.if_valid !== 1'b1 || bus.if_instr !== 32'h100 + 32'(4 * k)
                || bus.if_pc_plus4 !== 32'(4 * (k + 1))) begin
                bad++;
                $display("FAIL stream_%0d got v=%b i=%h p=%h want 1/%h/%h", k, bus.if_valid,
                         bus.if_instr, bus.if_pc_plus4, 32'h100 + 32'(4 * k), 32'(4 * (k + 1)));
            end
        end
    endtask

    task automatic test_stall();
        bus.stall = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'hC || bus.if_valid !== 1'b1
                || bus.if_instr !== 32'h108 || bus.if_pc_plus4 !== 32'hC) begin
                bad++;
                $display("FAIL stall_hold_%0d got req=%b addr=%h v=%b i=%h p=%h want 0/c/1/108/c",
                         k, bus.imem_req, bus.imem_addr, bus.if_valid, bus.if_instr, bus.if_pc_plus4);
            end
            tick();
        end
        bus.stall = 1'b0;
        #1;
        tick();
        total++;
        if (bus.if_valid !== 1'b1 || bus.if_instr !== 32'h10C || bus.if_pc_plus4 !== 32'h10) begin
            bad++;
            $display("FAIL stall_release got v=%b i=%h p=%h want 1/10c/10",
                     bus.if_valid, bus.if_instr, bus.if_pc_plus4);
        end
    endtask

    task automatic test_not_ready();
        bus.imem_ready = 1'b0;
        #1;
        total++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) begin
            bad++;
            $display("FAIL nr_req got req=%b addr=%h want 1/10", bus.imem_req, bus.imem_addr);
        end
        tick();
        total++;
        if (bus.if_valid !== 1'b0 || bus.if_instr !== 32'h0 || bus.if_pc_plus4 !== 32'h10
            || bus.imem_addr !== 32'h10 || bus.imem_req !== 1'b1) begin
            bad++;
            $display("FAIL nr_bubble got v=%b i=%h p=%h addr=%h req=%b want 0/0/10/10/1",
                     bus.if_valid, bus.if_instr, bus.if_pc_plus4, bus.imem_addr, bus.imem_req);
        end
        tick();
        total++;
        if (bus.if_valid !== 1'b0 || bus.imem_addr !== 32'h10) begin
            bad++;
            $display("FAIL nr_second got v=%b addr=%h want 0/10", bus.if_valid, bus.imem_addr);
        end
        bus.imem_ready = 1'b1;
        tick();
        total++;
        if (bus.if_valid !== 1'b1 || bus.if_instr !== 32'h110 || bus.if_pc_plus4 !== 32'h14) begin
            bad++;
            $display("FAIL nr_resume got v=%b i=%h p=%h want 1/110/14",
                     bus.if_valid, bus.if_instr, bus.if_pc_plus4);
        end
    endtask

    task automatic test_redirect();
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0000_0403;
        #1;
        total++;
        if (bus.imem_req !== 1'b0) begin
            bad++;
            $display("FAIL redir_req got %b want 0", bus.imem_req);
        end
        tick();
        total++;
        if (bus.if_valid !== 1'b0 || bus.if_instr !== 32'h0 || bus.imem_addr !== 32'h400) begin
            bad++;
            $display("FAIL redir_flush got v=%b i=%h addr=%h want 0/0/400",
                     bus.if_valid, bus.if_instr, bus.imem_addr);
        end
        bus.redirect = 1'b0;
        #1;
        total++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h400) begin
            bad++;
            $display("FAIL redir_refetch got req=%b addr=%h want 1/400", bus.imem_req, bus.imem_addr);
        end
        tick();
        total++;
        if (bus.if_valid !== 1'b1 || bus.if_instr !== 32'h500 || bus.if_pc_plus4 !== 32'h404) begin
            bad++;
            $display("FAIL redir_target got v=%b i=%h p=%h want 1/500/404",
                     bus.if_valid, bus.if_instr, bus.if_pc_plus4);
        end
    endtask

    task automatic test_redirect_stall();
        bus.stall = 1'b1;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0000_0800;
        tick();
        total++;
        if (bus.if_valid !== 1'b0 || bus.if_instr !== 32'h0 || bus.imem_addr !== 32'h800) begin
            bad++;
            $display("FAIL rs_flush got v=%b i=%h addr=%h want 0/0/800",
                     bus.if_valid, bus.if_instr, bus.imem_addr);
        end
        bus.redirect = 1'b0;
        tick();
        total++;
        if (bus.if_valid !== 1'b1 || bus.if_instr !== 32'h900 || bus.if_pc_plus4 !== 32'h804) begin
            bad++;
            $display("FAIL rs_fill_empty got v=%b i=%h p=%h want 1/900/804",
                     bus.if_valid, bus.if_instr, bus.if_pc_plus4);
        end
        tick();
        total++;
        if (bus.if_instr !== 32'h900 || bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h804) begin
            bad++;
            $display("FAIL rs_hold got i=%h req=%b addr=%h want 900/0/804",
                     bus.if_instr, bus.imem_req, bus.imem_addr);
        end
        bus.stall = 1'b0;
    endtask

    task automatic test_wrap();
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        tick();
        bus.redirect = 1'b0;
        total++;
        if (bus.imem_addr !== 32'hFFFF_FFFC) begin
            bad++;
            $display("FAIL wrap_addr got %h want fffffffc", bus.imem_addr);
        end
        tick();
        total++;
        if (bus.if_valid !== 1'b1 || bus.if_instr !== 32'h0000_00FC || bus.if_pc_plus4 !== 32'h0
            || bus.imem_addr !== 32'h0) begin
            bad++;
            $display("FAIL wrap_slot got v=%b i=%h p=%h addr=%h want 1/fc/0/0",
                     bus.if_valid, bus.if_instr, bus.if_pc_plus4, bus.imem_addr);
        end
        tick();
        total++;
        if (bus.if_instr !== 32'h100 || bus.if_pc_plus4 !== 32'h4) begin
            bad++;
            $display("FAIL wrap_next got i=%h p=%h want 100/4", bus.if_instr, bus.if_pc_plus4);
        end
    endtask

    task automatic test_async_reset();
        tick();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (bus.if_valid !== 1'b0 || bus.if_instr !== 32'h0 || bus.if_pc_plus4 !== 32'h0
            || bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0) begin
            bad++;
            $display("FAIL async_reset got v=%b i=%h p=%h req=%b addr=%h want all zero",
                     bus.if_valid, bus.if_instr, bus.if_pc_plus4, bus.imem_req, bus.imem_addr);
        end
        #1;
        rst = 1'b0;
        tick();
        total++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.if_valid !== 1'b0) begin
            bad++;
            $display("FAIL post_reset got req=%b addr=%h v=%b want 1/0/0",
                     bus.imem_req, bus.imem_addr, bus.if_valid);
        end
        tick();
        total++;
        if (bus.if_valid !== 1'b1 || bus.if_instr !== 32'h100 || bus.if_pc_plus4 !== 32'h4) begin
            bad++;
            $display("FAIL post_reset_fetch got v=%b i=%h p=%h want 1/100/4",
                     bus.if_valid, bus.if_instr, bus.if_pc_plus4);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_stall();
        test_not_ready();
        test_redirect();
        test_redirect_stall();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
